// File: rtl/ga23_rom_arbiter.sv
// ga23 tile-ROM arbiter: shares one 64-bit toggle-handshake SDRAM channel between three
// 32-bit tile-layer fetch ports, with a one-line cache per port so that the second half
// of a line is served locally.
`timescale 1ns / 1ps

module ga23_rom_arbiter #(
  parameter logic [24:0] BASE_ADDR = 25'h0000000,
  parameter bit          CACHE_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic [21:0] addr_a,
  input  logic [21:0] addr_b,
  input  logic [21:0] addr_c,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        req_c,
  output logic [31:0] data_a,
  output logic [31:0] data_b,
  output logic [31:0] data_c,
  output logic        rdy_a,
  output logic        rdy_b,
  output logic        rdy_c,

  output logic [24:0] sdr_addr,
  output logic        sdr_req,
  input  logic        sdr_rdy,
  input  logic [63:0] sdr_data
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDeliver} state_e;

  state_e      state_q;
  logic [1:0]  ptr_q;
  logic [1:0]  gnt_q;
  logic [21:0] gaddr_q;
  logic        sdr_req_q;
  logic [24:0] sdr_addr_q;

  logic [2:0]  rdy_q;
  logic [31:0] data_q  [3];
  logic [63:0] line_q  [3];
  logic [20:0] tag_q   [3];
  logic [2:0]  valid_q;

  logic [21:0] addr    [3];
  logic [2:0]  req;
  logic [2:0]  pending;
  logic [2:0]  hit;
  logic [2:0]  miss_cand;
  logic [1:0]  pick;
  logic        pick_vld;
  logic [1:0]  ptr_p1;
  logic [1:0]  ptr_p2;
  logic [24:0] gline_addr;

  // Round-robin successor: c wraps back to a.
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign addr[0] = addr_a;
  assign addr[1] = addr_b;
  assign addr[2] = addr_c;
  assign req     = {req_c, req_b, req_a};

  assign rdy_a    = rdy_q[0];
  assign rdy_b    = rdy_q[1];
  assign rdy_c    = rdy_q[2];
  assign data_a   = data_q[0];
  assign data_b   = data_q[1];
  assign data_c   = data_q[2];
  assign sdr_req  = sdr_req_q;
  assign sdr_addr = sdr_addr_q;

  // Line byte address; the sum wraps at 25 bits.
  assign gline_addr = BASE_ADDR + {1'b0, gaddr_q[21:1], 3'b000};

  // Pending/hit decode; the granted port is kept out of the hit check until it is delivered.
  always_comb begin
    pending   = '0;
    hit       = '0;
    miss_cand = '0;
    for (int i = 0; i < 3; i++) begin
      pending[i]   = req[i] ^ rdy_q[i];
      hit[i]       = CACHE_EN && pending[i] && valid_q[i] && (tag_q[i] == addr[i][21:1]) &&
                     !((state_q != StIdle) && (gnt_q == 2'(i)));
      miss_cand[i] = pending[i] & ~hit[i];
    end
  end

  // First missing port at or after the round-robin pointer.
  always_comb begin
    ptr_p1   = next_port(ptr_q);
    ptr_p2   = next_port(ptr_p1);
    pick     = ptr_q;
    pick_vld = 1'b0;
    if (miss_cand[ptr_q]) begin
      pick     = ptr_q;
      pick_vld = 1'b1;
    end else if (miss_cand[ptr_p1]) begin
      pick     = ptr_p1;
      pick_vld = 1'b1;
    end else if (miss_cand[ptr_p2]) begin
      pick     = ptr_p2;
      pick_vld = 1'b1;
    end
  end

  // Hit responses, miss FSM, cache fill and SDRAM handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ptr_q      <= 2'd0;
      gnt_q      <= 2'd0;
      gaddr_q    <= '0;
      sdr_req_q  <= 1'b0;
      sdr_addr_q <= BASE_ADDR;
      valid_q    <= '0;
      rdy_q      <= '0;
      for (int i = 0; i < 3; i++) begin
        data_q[i] <= '0;
        line_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (hit[i]) begin
          data_q[i] <= addr[i][0] ? line_q[i][63:32] : line_q[i][31:0];
          rdy_q[i]  <= ~rdy_q[i];
        end
      end

      case (state_q)
        StIdle: begin
          if (pick_vld) begin
            gnt_q   <= pick;
            gaddr_q <= addr[pick];
            state_q <= StIssue;
          end
        end
        StIssue: begin
          sdr_addr_q <= gline_addr;
          sdr_req_q  <= ~sdr_req_q;
          state_q    <= StWait;
        end
        StWait: begin
          if (sdr_rdy == sdr_req_q) begin
            line_q[gnt_q]  <= sdr_data;
            tag_q[gnt_q]   <= gaddr_q[21:1];
            valid_q[gnt_q] <= CACHE_EN;
            state_q        <= StDeliver;
          end
        end
        StDeliver: begin
          data_q[gnt_q] <= gaddr_q[0] ? line_q[gnt_q][63:32] : line_q[gnt_q][31:0];
          rdy_q[gnt_q]  <= ~rdy_q[gnt_q];
          ptr_q         <= next_port(gnt_q);
          state_q       <= StIdle;
        end
      endcase
    end
  end

endmodule
